seg_scan_display: RTL

//  Parametrised multiplexed seven-segment scanner: time-multiplexes N_DIGITS hex digits onto a shared

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_hex_decoder.sv | 11 +
 rtl/seg_scan_display.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared segment encoding for the multiplexed seven-segment scanner.
// Segment byte layout is active-low {a,b,c,d,e,f,g,dp} with a in bit 7.
package seg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_OFF = 8'hFF;

    localparam int SEG_A  = 7;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Entry n is the full active-low pattern for hex digit n with dp dark.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
        seg_t pattern;
        pattern = HEX_SEG[nib];
        return pattern[SEG_A:SEG_G];
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to seven-segment (a..g, active-low) decoder.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg7
);

    assign seg7 = hex_to_seg7(nib);

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with anti-ghost blanking and frame-synchronous data update.
// Optional build macro SEG_LZ_SUPPRESS_EN enables leading-zero suppression on the displayed data.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int DIV_W        = 15,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  load,
    output logic                  upd_pend,
    output logic                  frame_start,
    output logic [N_DIGITS-1:0]   dig_sel,
    output logic [7:0]            seg
);

    localparam int               IDX_W     = $clog2(N_DIGITS);
    localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);

    logic [DIV_W-1:0]      div_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [4*N_DIGITS-1:0] pend_data_reg, act_data_reg;
    logic [N_DIGITS-1:0]   pend_dp_reg, act_dp_reg;
    logic [N_DIGITS-1:0]   pend_blank_reg, act_blank_reg;
    logic                  upd_pend_reg;
    logic                  frame_start_reg;
    logic [N_DIGITS-1:0]   dig_sel_reg, dig_sel_next;
    seg_t                  seg_reg, seg_next;

    logic                  terminal;
    logic                  boundary;
    logic [3:0]            nib [N_DIGITS];
    logic [N_DIGITS-1:0]   one_hot;
    logic [N_DIGITS-1:0]   lz_mask;
    logic [N_DIGITS-1:0]   eff_blank;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_seg7;

    assign terminal = &div_reg;
    assign boundary = terminal && (idx_reg == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_reg <= '0;
            idx_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
            if (terminal) begin
                idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
            end
        end
    end

    // Active data only moves at the frame boundary so a frame never mixes old and new values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_data_reg   <= '0;
            pend_dp_reg     <= '0;
            pend_blank_reg  <= '0;
            act_data_reg    <= '0;
            act_dp_reg      <= '0;
            act_blank_reg   <= '0;
            upd_pend_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= boundary;
            if (load) begin
                pend_data_reg  <= data_in;
                pend_dp_reg    <= dp_in;
                pend_blank_reg <= blank_in;
            end
            if (boundary && load) begin
                act_data_reg  <= data_in;
                act_dp_reg    <= dp_in;
                act_blank_reg <= blank_in;
                upd_pend_reg  <= 1'b0;
            end else if (boundary && upd_pend_reg) begin
                act_data_reg  <= pend_data_reg;
                act_dp_reg    <= pend_dp_reg;
                act_blank_reg <= pend_blank_reg;
                upd_pend_reg  <= 1'b0;
            end else if (load) begin
                upd_pend_reg  <= 1'b1;
            end
        end
    end

    // Digit 0 is the leftmost nibble (most significant bits of the bus).
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign nib[gi]     = act_data_reg[4*(N_DIGITS-gi)-1 -: 4];
            assign one_hot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

`ifdef SEG_LZ_SUPPRESS_EN
    // Scan from the left; zeros without dp ahead of the first visible significant digit go dark.
    always_comb begin : lz_scan
        logic leading;
        leading = 1'b1;
        lz_mask = '0;
        for (int i = 0; i < N_DIGITS - 1; i++) begin
            if (leading && (nib[i] == 4'd0) && !act_dp_reg[i]) begin
                lz_mask[i] = 1'b1;
            end
            if (!act_blank_reg[i] && ((nib[i] != 4'd0) || act_dp_reg[i])) begin
                leading = 1'b0;
            end
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign eff_blank = act_blank_reg | lz_mask;
    assign cur_nib   = nib[idx_reg];

    seg_hex_decoder u_dec (
        .nib  (cur_nib),
        .seg7 (cur_seg7)
    );

    always_comb begin
        dig_sel_next = '0;
        seg_next     = SEG_OFF;
        if (div_reg >= BLANK_LIM) begin
            dig_sel_next = one_hot;
            if (!eff_blank[idx_reg]) begin
                seg_next[SEG_A:SEG_G] = cur_seg7;
                seg_next[SEG_DP]      = ~act_dp_reg[idx_reg];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig_sel_reg <= '0;
            seg_reg     <= SEG_OFF;
        end else begin
            dig_sel_reg <= dig_sel_next;
            seg_reg     <= seg_next;
        end
    end

    assign upd_pend    = upd_pend_reg;
    assign frame_start = frame_start_reg;
    assign dig_sel     = dig_sel_reg;
    assign seg         = seg_reg;

endmodule
